// File: rtl/ringosc_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
package ringosc_meter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESET   = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    DONE    = 3'd4
  } meter_state_e;

  localparam int SETTLE_CYCLES = 3;

  // Wide enough to hold N-1 for the longest window, 2^(2^sel_w - 1 + min_log2) - 1.
  function automatic int gate_cnt_w(input int sel_w, input int min_log2);
    return min_log2 + (1 << sel_w) - 1;
  endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchronizer for the asynchronous ring-counter bit, plus a
// previous-value flop so rising edges appear as single-cycle pulses.
module osc_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic osc_i,
  output logic edge_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = osc_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/ringosc_freq_meter.sv
// Counts rising edges of a ring-counter bit over a power-of-two gate window
// and presents a saturating count on a valid/ready interface.
//
// state   | meaning
// IDLE    | ring stopped, waiting for start_i
// RESET   | ring counter held in reset for RST_CYCLES cycles
// SETTLE  | ring running, synchronizer flushed, edges ignored
// MEASURE | edges counted for N = 2^(sel+GATE_MIN_LOG2) cycles
// DONE    | ring stopped, result held until ready_i
module ringosc_freq_meter
  import ringosc_meter_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int GATE_SEL_W    = 4,
  parameter int GATE_MIN_LOG2 = 4,
  parameter int RST_CYCLES    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [GATE_SEL_W-1:0] gate_sel_i,
  input  logic                  osc_i,
  output logic                  ring_reset_o,
  output logic                  ring_stop_o,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      result_o,
  output logic                  overflow_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int GATE_W = gate_cnt_w(GATE_SEL_W, GATE_MIN_LOG2);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  meter_state_e          state_q, state_d;
  logic [GATE_W-1:0]     timer_q, timer_d;
  logic [GATE_SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [CNT_W-1:0]      result_q, result_d;
  logic                  overflow_q, overflow_d;
  logic                  valid_q, valid_d;
  logic                  ring_reset_q, ring_reset_d;
  logic                  ring_stop_q, ring_stop_d;
  logic                  busy_q, busy_d;

  logic                  osc_edge;
  logic [CNT_W-1:0]      cnt_next;
  logic                  ovf_next;
  logic [GATE_W:0]       gate_n;
  logic [GATE_W:0]       gate_n_m1;
  logic [GATE_W-1:0]     gate_load;

  osc_edge_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .osc_i  (osc_i),
    .edge_o (osc_edge)
  );

  // One extra bit so the largest window's N is representable before the -1.
  always_comb begin
    gate_n    = (GATE_W + 1)'(1) << (int'(sel_q) + GATE_MIN_LOG2);
    gate_n_m1 = gate_n - (GATE_W + 1)'(1);
    gate_load = gate_n_m1[GATE_W-1:0];
  end

  always_comb begin
    cnt_next = count_q;
    ovf_next = ovf_q;
    if (osc_edge) begin
      if (count_q == CNT_MAX) ovf_next = 1'b1;
      else                    cnt_next = count_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    sel_d      = sel_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          sel_d   = gate_sel_i;
          count_d = '0;
          ovf_d   = 1'b0;
          timer_d = GATE_W'(RST_CYCLES - 1);
          state_d = RESET;
        end
      end
      RESET: begin
        if (timer_q == '0) begin
          timer_d = GATE_W'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end else begin
          timer_d = timer_q - GATE_W'(1);
        end
      end
      SETTLE: begin
        if (timer_q == '0) begin
          timer_d = gate_load;
          state_d = MEASURE;
        end else begin
          timer_d = timer_q - GATE_W'(1);
        end
      end
      MEASURE: begin
        count_d = cnt_next;
        ovf_d   = ovf_next;
        if (timer_q == '0) begin
          result_d   = cnt_next;
          overflow_d = ovf_next;
          valid_d    = 1'b1;
          state_d    = DONE;
        end else begin
          timer_d = timer_q - GATE_W'(1);
        end
      end
      DONE: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with state_q.
    ring_reset_d = (state_d == RESET);
    ring_stop_d  = !((state_d == SETTLE) || (state_d == MEASURE));
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      sel_q        <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      result_q     <= '0;
      overflow_q   <= 1'b0;
      valid_q      <= 1'b0;
      ring_reset_q <= 1'b0;
      ring_stop_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      sel_q        <= sel_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      result_q     <= result_d;
      overflow_q   <= overflow_d;
      valid_q      <= valid_d;
      ring_reset_q <= ring_reset_d;
      ring_stop_q  <= ring_stop_d;
      busy_q       <= busy_d;
    end
  end

  assign ring_reset_o = ring_reset_q;
  assign ring_stop_o  = ring_stop_q;
  assign busy_o       = busy_q;
  assign result_o     = result_q;
  assign overflow_o   = overflow_q;
  assign valid_o      = valid_q;

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// Scoreboard bench for ringosc_freq_meter: a 16-bit instance for the main
// scenarios and a 4-bit instance for saturation.
module tb_ringosc_freq_meter;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        start4_i;
  logic [3:0]  gate_sel_i;
  logic        osc_i;
  logic        ready_i;

  logic        ring_reset_o, ring_stop_o, busy_o, overflow_o, valid_o;
  logic [15:0] result_o;
  logic        ring_reset4_o, ring_stop4_o, busy4_o, overflow4_o, valid4_o;
  logic [3:0]  result4_o;

  int          osc_period;
  int          osc_ph;
  logic        osc_gen;
  logic        osc_man;

  int          n_checks;
  int          n_errors;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
  } exp_t;
  exp_t sb_q[$];

  ringosc_freq_meter #(.CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .gate_sel_i   (gate_sel_i),
    .osc_i        (osc_i),
    .ring_reset_o (ring_reset_o),
    .ring_stop_o  (ring_stop_o),
    .busy_o       (busy_o),
    .result_o     (result_o),
    .overflow_o   (overflow_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i)
  );

  ringosc_freq_meter #(.CNT_W(4)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start4_i),
    .gate_sel_i   (gate_sel_i),
    .osc_i        (osc_i),
    .ring_reset_o (ring_reset4_o),
    .ring_stop_o  (ring_stop4_o),
    .busy_o       (busy4_o),
    .result_o     (result4_o),
    .overflow_o   (overflow4_o),
    .valid_o      (valid4_o),
    .ready_i      (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running oscillator when osc_period != 0, otherwise driven by osc_man.
  always @(negedge clk) begin
    if (osc_period != 0) begin
      osc_ph  = (osc_ph + 1) % osc_period;
      osc_gen = (osc_ph < osc_period / 2);
    end
  end
  assign osc_i = (osc_period == 0) ? osc_man : osc_gen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [3:0] sel, input bit use4, input bit push,
                             input logic [15:0] res, input logic ovf);
    exp_t e;
    @(negedge clk);
    gate_sel_i = sel;
    if (use4) start4_i = 1'b1;
    else      start_i  = 1'b1;
    if (push) begin
      e.res = res;
      e.ovf = ovf;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start_i  = 1'b0;
    start4_i = 1'b0;
  endtask

  task automatic wait_valid(input bit use4, input int limit);
    int n;
    n = 0;
    while (((use4 ? valid4_o : valid_o) !== 1'b1) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", {31'd0, (use4 ? valid4_o : valid_o)}, 32'd1);
  endtask

  task automatic pop_check(input string tag, input bit use4);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      if (use4) chk({tag, "_result"}, {28'd0, result4_o}, {16'd0, e.res});
      else      chk({tag, "_result"}, {16'd0, result_o}, {16'd0, e.res});
      chk({tag, "_ovf"}, {31'd0, (use4 ? overflow4_o : overflow_o)}, {31'd0, e.ovf});
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  task automatic wait_stop_low();
    int n;
    n = 0;
    while (ring_stop_o !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stop_low_timeout", {31'd0, ring_stop_o}, 32'd0);
  endtask

  initial begin
    int n;
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    start4_i   = 1'b0;
    gate_sel_i = '0;
    ready_i    = 1'b0;
    osc_period = 8;
    osc_ph     = 0;
    osc_gen    = 1'b0;
    osc_man    = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ring_reset", {31'd0, ring_reset_o}, 32'd0);
    chk("rst_ring_stop",  {31'd0, ring_stop_o},  32'd1);
    chk("rst_busy",       {31'd0, busy_o},       32'd0);
    chk("rst_valid",      {31'd0, valid_o},      32'd0);
    chk("rst_result",     {16'd0, result_o},     32'd0);
    chk("rst_ovf",        {31'd0, overflow_o},   32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Period 8, N=16: two edges, ring reset pulse of 4 cycles.
    pulse_start(4'd0, 1'b0, 1'b1, 16'd2, 1'b0);
    n = 0;
    while (ring_reset_o === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("ring_reset_len", n, 32'd4);
    wait_valid(1'b0, 200);
    pop_check("n16", 1'b0);
    handshake();
    chk("n16_valid_drop", {31'd0, valid_o}, 32'd0);
    chk("n16_idle", {31'd0, busy_o}, 32'd0);

    // N=64 with ready held high: valid lasts exactly one cycle.
    ready_i = 1'b1;
    pulse_start(4'd2, 1'b0, 1'b1, 16'd8, 1'b0);
    wait_valid(1'b0, 300);
    pop_check("n64", 1'b0);
    n = 0;
    while (valid_o === 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("n64_valid_len", n, 32'd1);
    ready_i = 1'b0;

    // 4-bit counter, 16 edges in 64 cycles: saturates.
    osc_period = 4;
    pulse_start(4'd2, 1'b1, 1'b1, 16'd15, 1'b1);
    wait_valid(1'b1, 300);
    pop_check("sat", 1'b1);
    handshake();
    chk("sat_valid_drop", {31'd0, valid4_o}, 32'd0);

    // Backpressure: result held for 10 cycles, start ignored in DONE.
    osc_period = 8;
    pulse_start(4'd0, 1'b0, 1'b1, 16'd2, 1'b0);
    wait_valid(1'b0, 200);
    pop_check("bp", 1'b0);
    for (int i = 0; i < 10; i++) begin
      start_i = (i == 3);
      @(negedge clk);
      chk("bp_hold", {13'd0, valid_o, busy_o, overflow_o, result_o},
          {13'd0, 1'b1, 1'b1, 1'b0, 16'd2});
    end
    start_i = 1'b1;
    ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    ready_i = 1'b0;
    chk("bp_idle_busy",  {31'd0, busy_o},  32'd0);
    chk("bp_idle_valid", {31'd0, valid_o}, 32'd0);
    repeat (2) @(negedge clk);
    chk("bp_start_ignored", {31'd0, busy_o}, 32'd0);

    // Synchronous reset mid-MEASURE aborts without a result.
    pulse_start(4'd2, 1'b0, 1'b0, 16'd0, 1'b0);
    wait_stop_low();
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy",       {31'd0, busy_o},       32'd0);
    chk("abort_valid",      {31'd0, valid_o},      32'd0);
    chk("abort_result",     {16'd0, result_o},     32'd0);
    chk("abort_ring_stop",  {31'd0, ring_stop_o},  32'd1);
    chk("abort_ring_reset", {31'd0, ring_reset_o}, 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_valid", {31'd0, valid_o}, 32'd0);
    pulse_start(4'd0, 1'b0, 1'b1, 16'd2, 1'b0);
    wait_valid(1'b0, 200);
    pop_check("fresh", 1'b0);
    handshake();

    // Constant-high oscillator: no edges inside the window.
    osc_man    = 1'b1;
    osc_period = 0;
    repeat (4) @(negedge clk);
    pulse_start(4'd0, 1'b0, 1'b1, 16'd0, 1'b0);
    wait_valid(1'b0, 200);
    pop_check("const1", 1'b0);
    handshake();

    // Rise timed so the edge pulse lands in the last MEASURE cycle.
    osc_man = 1'b0;
    repeat (4) @(negedge clk);
    pulse_start(4'd0, 1'b0, 1'b1, 16'd1, 1'b0);
    wait_stop_low();
    repeat (16) @(negedge clk);
    osc_man = 1'b1;
    wait_valid(1'b0, 200);
    pop_check("last_edge", 1'b0);
    handshake();

    // One cycle later the edge falls outside the window.
    osc_man = 1'b0;
    repeat (4) @(negedge clk);
    pulse_start(4'd0, 1'b0, 1'b1, 16'd0, 1'b0);
    wait_stop_low();
    repeat (17) @(negedge clk);
    osc_man = 1'b1;
    wait_valid(1'b0, 200);
    pop_check("late_edge", 1'b0);
    handshake();

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ringosc_freq_meter.md
Name: ringosc_freq_meter

Overview:
Frequency-measurement stage paired with tt_um_urish_ringosc_cnt. It controls the ring-oscillator counter through that block's reset and stop inputs, and consumes one of its count bits as osc_i. It counts rising edges of osc_i over a programmable gate window in the clk domain. It presents a saturating result to downstream logic over a valid/ready handshake.

Parameters:
CNT_W, 16, width of the edge-count result
GATE_SEL_W, 4, width of gate_sel_i
GATE_MIN_LOG2, 4, log2 of the shortest gate window in clk cycles
RST_CYCLES, 4, number of clk cycles ring_reset_o is held high per measurement

Ports:
clk  input  1  system clock; all logic is rising-edge
rst_n  input  1  reset, synchronous, active-low
start_i  input  1  single-cycle request to begin a measurement; sampled only in IDLE
gate_sel_i  input  GATE_SEL_W  gate length = 2^(gate_sel_i+GATE_MIN_LOG2) cycles; latched on an accepted start
osc_i  input  1  asynchronous ring-counter bit to be measured
ring_reset_o  output  1  drives the ring-counter reset input
ring_stop_o  output  1  drives the ring-counter stop input
busy_o  output  1  high in every state except IDLE
result_o  output  CNT_W  edge count for the last completed window
overflow_o  output  1  the count saturated during the last window
valid_o  output  1  result_o and overflow_o are valid
ready_i  input  1  downstream accepts the result

Behaviour:
- Reset is synchronous on rst_n=0. Reset values:
  - state=IDLE, ring_reset_o=0, ring_stop_o=1, busy_o=0
  - result_o=0, overflow_o=0, valid_o=0
  - sync/edge flops=0, all counters=0
- Reset asserted mid-operation aborts the measurement immediately; no partial result is presented.
- osc_i passes through a 2-flop synchronizer, then a previous-value flop.
  - edge = sync2 & ~prev.
  - Guaranteed operating range: osc_i high and low phases each ≥2 clk periods.
- FSM states: IDLE, RESET, SETTLE, MEASURE, DONE.
- IDLE:
  - ring_stop_o=1.
  - On start_i=1: latch gate_sel_i, clear the edge count and overflow, go to RESET.
- RESET:
  - ring_reset_o=1 and ring_stop_o=1 for exactly RST_CYCLES cycles, then go to SETTLE.
- SETTLE:
  - ring_reset_o=0, ring_stop_o=0 for exactly 3 cycles to flush the synchronizer. Edges are ignored.
  - Load the gate counter with N-1, where N = 2^(sel+GATE_MIN_LOG2).
  - Go to MEASURE.
- MEASURE:
  - ring_stop_o=0. Each cycle, if edge=1, the count increments.
  - The count saturates at 2^CNT_W-1. An increment attempted at saturation sets overflow.
  - The gate counter decrements each cycle.
  - In the cycle the gate counter is 0, that cycle's edge is still included, and the next state is DONE. Exactly N cycles are sampled.
- DONE:
  - ring_stop_o=1.
  - result_o and overflow_o are registered on entry. valid_o=1 from the first DONE cycle.
  - result_o and overflow_o are held stable while valid_o=1 and ready_i=0.
  - When valid_o & ready_i: handshake completes, valid_o drops in the next cycle, state returns to IDLE.
  - result_o and overflow_o retain their value until the next DONE entry.
- start_i is ignored in every state other than IDLE, including the handshake cycle.
- ready_i is ignored while valid_o=0.
- Gate counter width = GATE_MIN_LOG2 + 2^GATE_SEL_W - 1 bits. gate_sel_i is unsigned; every value is legal.
- Edge count arithmetic is unsigned, CNT_W bits, with no wrap-around.

Decomposition:
- Package ringosc_meter_pkg:
  - FSM state enum (IDLE, RESET, SETTLE, MEASURE, DONE)
  - SETTLE_CYCLES=3 constant
  - gate-counter width function of GATE_SEL_W and GATE_MIN_LOG2
- Sub-module osc_edge_sync: 2-flop synchronizer plus previous-value flop. Input osc_i, output edge; clk and rst_n as above.

Test Plan:
- osc_i period 8 clk (4 high/4 low), gate_sel=0 (N=16), start pulse -> ring_reset_o high exactly 4 cycles, then valid_o=1 with result_o=2, overflow_o=0.
- Same osc_i, gate_sel=2 (N=64) -> result_o=8; ready_i held high -> valid_o high for exactly 1 cycle.
- CNT_W=4, osc_i period 4 clk, gate_sel=2 (64 cycles, 16 edges) -> result_o=15, overflow_o=1.
- ready_i low for 10 cycles after valid_o, start_i pulsed during that time -> valid_o, result_o and overflow_o stable; start ignored; busy_o=1; IDLE reached one cycle after ready_i=1.
- rst_n=0 for 1 cycle mid-MEASURE -> next cycle state IDLE, valid_o=0, result_o=0, ring_stop_o=1, ring_reset_o=0; a subsequent start yields a correct fresh count.
- osc_i constant 1 across the whole window -> result_o=0; an osc_i edge placed in the last MEASURE cycle is counted (result_o=1).
